// File: rtl/mcpu_v1.sv
// Multi-cycle MIPS-subset core: one shared memory port and a microsequenced datapath.
// Each instruction takes 3-5 cycles, and a debug read port exposes the register file.
module mcpu_v1 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Data_in,
  input  logic        INT,
  input  logic        MIO_ready,
  input  logic [4:0]  test_reg_index,
  output logic        mem_w,
  output logic [31:0] Addr_out,
  output logic [31:0] Data_out,
  output logic [4:0]  state,
  output logic [31:0] PC_out,
  output logic [31:0] inst_out,
  output logic [31:0] test_reg_result,
  output logic        CPU_MIO
);

  typedef enum logic [4:0] {
    S_IF      = 5'd0,
    S_ID      = 5'd1,
    S_MEMADDR = 5'd2,
    S_MEMREAD = 5'd3,
    S_LWWB    = 5'd4,
    S_MEMWR   = 5'd5,
    S_REXE    = 5'd6,
    S_RWB     = 5'd7,
    S_BEQ     = 5'd8,
    S_BNE     = 5'd9,
    S_JUMP    = 5'd10,
    S_IEXE    = 5'd11,
    S_IWB     = 5'd12,
    S_JAL     = 5'd13,
    S_JALR    = 5'd14
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  state_t      r_state, w_next;
  logic [31:0] r_pc, r_ir, r_mdr, r_a, r_b, r_aluout;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op, w_fn;
  logic [4:0]  w_rs, w_rt, w_rd, w_sh;
  logic [15:0] w_imm;
  logic [31:0] w_sext, w_zext, w_jtarget, w_alu;
  logic        w_we;
  logic [4:0]  w_wa;
  logic [31:0] w_wd;
  logic        w_unused;

  assign w_op      = r_ir[31:26];
  assign w_rs      = r_ir[25:21];
  assign w_rt      = r_ir[20:16];
  assign w_rd      = r_ir[15:11];
  assign w_sh      = r_ir[10:6];
  assign w_fn      = r_ir[5:0];
  assign w_imm     = r_ir[15:0];
  assign w_sext    = {{16{w_imm[15]}}, w_imm};
  assign w_zext    = {16'h0000, w_imm};
  assign w_jtarget = {r_pc[31:28], r_ir[25:0], 2'b00};
  assign w_unused  = ^{INT, MIO_ready};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IF;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF: w_next = S_ID;
      S_ID: begin
        case (w_op)
          OP_LW, OP_SW: w_next = S_MEMADDR;
          OP_R:         w_next = (w_fn == FN_JALR) ? S_JALR : S_REXE;
          OP_BEQ:       w_next = S_BEQ;
          OP_BNE:       w_next = S_BNE;
          OP_J:         w_next = S_JUMP;
          OP_JAL:       w_next = S_JAL;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: w_next = S_IEXE;
          default:      w_next = S_IF;
        endcase
      end
      S_MEMADDR: w_next = (w_op == OP_LW) ? S_MEMREAD : S_MEMWR;
      S_MEMREAD: w_next = S_LWWB;
      S_REXE:    w_next = S_RWB;
      S_IEXE:    w_next = S_IWB;
      default:   w_next = S_IF;
    endcase
  end

  always_comb begin
    w_alu = '0;
    if (r_state == S_REXE) begin
      case (w_fn)
        FN_ADD:  w_alu = r_a + r_b;
        FN_SUB:  w_alu = r_a - r_b;
        FN_AND:  w_alu = r_a & r_b;
        FN_OR:   w_alu = r_a | r_b;
        FN_XOR:  w_alu = r_a ^ r_b;
        FN_NOR:  w_alu = ~(r_a | r_b);
        FN_SLT:  w_alu = {31'b0, $signed(r_a) < $signed(r_b)};
        FN_SLL:  w_alu = r_b << w_sh;
        FN_SRL:  w_alu = r_b >> w_sh;
        default: w_alu = '0;
      endcase
    end else begin
      case (w_op)
        OP_ADDI: w_alu = r_a + w_sext;
        OP_SLTI: w_alu = {31'b0, $signed(r_a) < $signed(w_sext)};
        OP_ANDI: w_alu = r_a & w_zext;
        OP_ORI:  w_alu = r_a | w_zext;
        OP_XORI: w_alu = r_a ^ w_zext;
        OP_LUI:  w_alu = {w_imm, 16'h0000};
        default: w_alu = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc     <= '0;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
    end else begin
      case (r_state)
        S_IF: begin
          r_ir <= Data_in;
          r_pc <= r_pc + 32'd4;
        end
        S_ID: begin
          r_a      <= r_rf[w_rs];
          r_b      <= r_rf[w_rt];
          r_aluout <= r_pc + {w_sext[29:0], 2'b00};
        end
        S_MEMADDR:      r_aluout <= r_a + w_sext;
        S_MEMREAD:      r_mdr    <= Data_in;
        S_REXE, S_IEXE: r_aluout <= w_alu;
        S_BEQ:          if (r_a == r_b) r_pc <= r_aluout;
        S_BNE:          if (r_a != r_b) r_pc <= r_aluout;
        S_JUMP, S_JAL:  r_pc <= w_jtarget;
        S_JALR:         r_pc <= r_a;
        default: ;
      endcase
    end
  end

  // Link writes use the already-incremented PC, sampled before this edge updates it.
  always_comb begin
    w_we = 1'b0;
    w_wa = '0;
    w_wd = '0;
    case (r_state)
      S_LWWB: begin w_we = 1'b1; w_wa = w_rt;  w_wd = r_mdr;    end
      S_RWB:  begin w_we = 1'b1; w_wa = w_rd;  w_wd = r_aluout; end
      S_IWB:  begin w_we = 1'b1; w_wa = w_rt;  w_wd = r_aluout; end
      S_JAL:  begin w_we = 1'b1; w_wa = 5'd31; w_wd = r_pc;     end
      S_JALR: begin w_we = 1'b1; w_wa = w_rd;  w_wd = r_pc;     end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < 32; i++) r_rf[i] <= '0;
    end else if (w_we && (w_wa != 5'd0)) begin
      r_rf[w_wa] <= w_wd;
    end
  end

  assign mem_w           = (r_state == S_MEMWR);
  assign Addr_out        = (r_state == S_MEMREAD || r_state == S_MEMWR) ? r_aluout : r_pc;
  assign Data_out        = r_b;
  assign state           = r_state;
  assign PC_out          = r_pc;
  assign inst_out        = r_ir;
  assign test_reg_result = (test_reg_index == 5'd0) ? 32'h0 : r_rf[test_reg_index];
  assign CPU_MIO         = (r_state == S_IF || r_state == S_MEMREAD || r_state == S_MEMWR);

endmodule

// File: tb/tb_mcpu_v1.sv
// Self-checking bench for mcpu_v1: feeds an instruction stream and queues expected register/PC results.
// It also checks the cycle counts, the state sequence, the store strobe and an abort by mid-load reset.
module tb_mcpu_v1;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Data_in;
  logic        INT;
  logic        MIO_ready;
  logic [4:0]  test_reg_index;
  logic        mem_w;
  logic [31:0] Addr_out, Data_out, PC_out, inst_out, test_reg_result;
  logic [4:0]  state;
  logic        CPU_MIO;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic [4:0]  idx;
    logic [31:0] val;
    logic [31:0] pc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] pc_m;

  mcpu_v1 dut (
    .clk(clk), .reset(reset), .Data_in(Data_in), .INT(INT), .MIO_ready(MIO_ready),
    .test_reg_index(test_reg_index), .mem_w(mem_w), .Addr_out(Addr_out), .Data_out(Data_out),
    .state(state), .PC_out(PC_out), .inst_out(inst_out), .test_reg_result(test_reg_result),
    .CPU_MIO(CPU_MIO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int sh, input int fn);
    enc_r = {6'h00, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    enc_i = {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(input int op, input int t);
    enc_j = {op[5:0], t[25:0]};
  endfunction

  // Runs one instruction from IF; expected cycles, execute state and store count are bench constants.
  task automatic exec(input string name, input logic [31:0] instr, input logic [31:0] ld,
                      input int exp_cyc, input logic [4:0] exe_st, input int exp_stores,
                      input logic [31:0] st_addr, input logic [31:0] st_data);
    int n;
    int stores;
    check({name, "_if_state"}, {27'b0, state}, 32'd0);
    check({name, "_if_addr"}, Addr_out, pc_m);
    Data_in = instr;
    n = 0;
    stores = 0;
    do begin
      @(posedge clk); #1;
      Data_in = ld;
      n++;
      if (n == 1) begin
        check({name, "_id_state"}, {27'b0, state}, 32'd1);
        check({name, "_id_pc"}, PC_out, pc_m + 32'd4);
      end
      if (n == 2) check({name, "_exe_state"}, {27'b0, state}, {27'b0, exe_st});
      if (mem_w) begin
        stores++;
        check({name, "_st_addr"}, Addr_out, st_addr);
        check({name, "_st_data"}, Data_out, st_data);
      end
    end while (state != 5'd0 && n < 10);
    check({name, "_cycles"}, n, exp_cyc);
    check({name, "_stores"}, stores, exp_stores);
  endtask

  task automatic push(input string name, input int idx, input logic [31:0] val, input logic [31:0] pc);
    exp_t e;
    e.name = name;
    e.idx  = idx[4:0];
    e.val  = val;
    e.pc   = pc;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    test_reg_index = e.idx;
    #1;
    check({e.name, "_reg"}, test_reg_result, e.val);
    check({e.name, "_pc"}, PC_out, e.pc);
    pc_m = e.pc;
  endtask

  task automatic alu(input string name, input logic [31:0] instr, input int rd, input logic [31:0] val, input logic [4:0] exe_st);
    push(name, rd, val, pc_m + 32'd4);
    exec(name, instr, 32'h0, 4, exe_st, 0, 32'h0, 32'h0);
    pop_check();
  endtask

  initial begin
    reset = 1'b0;
    Data_in = '0;
    INT = 1'b0;
    MIO_ready = 1'b1;
    test_reg_index = 5'd1;
    pc_m = 32'h0;
    #23;
    check("rst_pc", PC_out, 32'h0);
    check("rst_state", {27'b0, state}, 32'd0);
    check("rst_ir", inst_out, 32'h0);
    check("rst_memw", {31'b0, mem_w}, 32'd0);
    check("rst_addr", Addr_out, 32'h0);
    check("rst_mio", {31'b0, CPU_MIO}, 32'd1);
    check("rst_reg1", test_reg_result, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    alu("addi",  enc_i(8'h08, 1, 1, 1),          1,  32'h1,        5'd11);
    alu("add",   enc_r(1, 1, 2, 0, 8'h20),        2,  32'h2,        5'd6);
    alu("ori",   enc_i(8'h0D, 3, 3, 3),          3,  32'h3,        5'd11);
    alu("sub",   enc_r(3, 2, 4, 0, 8'h22),        4,  32'h1,        5'd6);
    alu("nor",   enc_r(2, 3, 5, 0, 8'h27),        5,  32'hFFFFFFFC, 5'd6);
    alu("xor",   enc_r(2, 3, 6, 0, 8'h26),        6,  32'h1,        5'd6);
    alu("slt",   enc_r(2, 3, 7, 0, 8'h2A),        7,  32'h1,        5'd6);
    alu("slti",  enc_i(8'h0A, 7, 8, 16'hFFFF),   8,  32'h0,        5'd11);
    alu("sll",   enc_r(0, 1, 9, 31, 8'h00),       9,  32'h80000000, 5'd6);
    alu("srl",   enc_r(0, 9, 10, 31, 8'h02),      10, 32'h1,        5'd6);
    alu("or",    enc_r(10, 0, 11, 0, 8'h25),      11, 32'h1,        5'd6);
    alu("andi",  enc_i(8'h0C, 11, 12, 16'hFFFF), 12, 32'h1,        5'd11);
    alu("lui",   enc_i(8'h0F, 0, 13, 16'hFFFF),  13, 32'hFFFF0000, 5'd11);
    alu("xori",  enc_i(8'h0E, 13, 14, 0),        14, 32'hFFFF0000, 5'd11);

    check("beq_at", pc_m, 32'h38);
    push("beq", 0, 32'h0, 32'h3C);
    exec("beq", enc_i(8'h04, 14, 0, 16'hFFF1), 32'h0, 3, 5'd8, 0, 32'h0, 32'h0);
    pop_check();
    push("bne", 0, 32'h0, 32'h40);
    exec("bne", enc_i(8'h05, 0, 0, 16'hFFF0), 32'h0, 3, 5'd9, 0, 32'h0, 32'h0);
    pop_check();
    push("j", 0, 32'h0, 32'h44);
    exec("j", enc_j(8'h02, 32'h11), 32'h0, 3, 5'd10, 0, 32'h0, 32'h0);
    pop_check();

    push("sw", 14, 32'hFFFF0000, 32'h48);
    exec("sw", enc_i(8'h2B, 0, 14, 8), 32'h0, 4, 5'd2, 1, 32'h8, 32'hFFFF0000);
    pop_check();
    push("lw", 15, 32'h12345678, 32'h4C);
    exec("lw", enc_i(8'h23, 0, 15, 8), 32'h12345678, 5, 5'd2, 0, 32'h0, 32'h0);
    pop_check();

    push("jal", 31, 32'h50, 32'h58);
    exec("jal", enc_j(8'h03, 32'h16), 32'h0, 3, 5'd13, 0, 32'h0, 32'h0);
    pop_check();
    push("jalr", 16, 32'h5C, 32'h12345678);
    exec("jalr", enc_r(15, 0, 16, 0, 8'h09), 32'h0, 3, 5'd14, 0, 32'h0, 32'h0);
    pop_check();

    // Abort a load while it sits in MemRead.
    test_reg_index = 5'd15;
    Data_in = enc_i(8'h23, 0, 15, 8);
    repeat (3) begin
      @(posedge clk); #1;
      Data_in = 32'hDEADBEEF;
    end
    check("abort_pre_state", {27'b0, state}, 32'd3);
    check("abort_pre_addr", Addr_out, 32'h8);
    #1;
    reset = 1'b0;
    #1;
    check("abort_pc", PC_out, 32'h0);
    check("abort_state", {27'b0, state}, 32'd0);
    check("abort_reg15", test_reg_result, 32'h0);
    check("abort_memw", {31'b0, mem_w}, 32'd0);
    check("abort_addr", Addr_out, 32'h0);
    check("abort_mio", {31'b0, CPU_MIO}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    pc_m = 32'h0;

    alu("post_addi", enc_i(8'h08, 0, 20, 16'h0007), 20, 32'h7, 5'd11);
    check("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
